// File: rtl/axis_pkg.sv
// Shared types and widths for the AXI-Stream receive path.
package axis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } rx_state_t;

  localparam int AXIS_USER_W = 2;
  localparam int AXIS_DEST_W = 8;

  // Packed width of one stored beat: data + keep + user + id + last.
  function automatic int beat_w(input int dw);
    return dw + dw / 8 + AXIS_USER_W + 2;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Show-ahead synchronous FIFO; the head word is visible on o_dout whenever o_empty is low.
module axis_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/axi_stream_receiver.sv
// AXI-Stream slave: TDEST filter, null-beat discard, show-ahead buffering, per-packet beat count.
//   state | meaning
//   IDLE  | between packets; first beat decides accept or drop
//   RECV  | inside an accepted packet; beats go to the FIFO
//   DROP  | inside a rejected packet; beats are swallowed
module axi_stream_receiver
  import axis_pkg::*;
#(
  parameter int          DATA_WIDTH = 16,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  MY_DEST    = 8'h00
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    TVALID,
  output logic                    TREADY,
  input  logic [DATA_WIDTH-1:0]   TDATA,
  input  logic [DATA_WIDTH/8-1:0] TKEEP,
  input  logic [DATA_WIDTH/8-1:0] TSTRB,
  input  logic                    TLAST,
  input  logic [1:0]              TUSER,
  input  logic                    TID,
  input  logic [7:0]              TDEST,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [DATA_WIDTH/8-1:0] out_keep,
  output logic [1:0]              out_user,
  output logic                    out_id,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             pkt_len,
  output logic                    pkt_done,
  output logic                    drop_err
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int BW = beat_w(DATA_WIDTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic [KW-1:0]          keep;
    logic [AXIS_USER_W-1:0] user;
    logic                   id;
    logic                   last;
  } beat_t;

  rx_state_t   r_state;
  logic        r_rdy_en;
  logic [15:0] r_cnt;
  logic [15:0] r_pkt_len;
  logic        r_pkt_done;
  logic        r_drop_err;

  beat_t       w_in_beat;
  beat_t       w_head;
  logic [BW-1:0] w_fifo_dout;
  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_keep_any;
  logic        w_match;
  logic        w_store;
  logic        w_pop;
  logic [15:0] w_cnt_next;
  logic        w_unused_strb;

  // TSTRB is required to mirror TKEEP and carries no extra information.
  assign w_unused_strb = ^TSTRB;

  assign TREADY     = (r_state == DROP) ? 1'b1 : (r_rdy_en && !w_full);
  assign w_accept   = TVALID && TREADY;
  assign w_keep_any = |TKEEP;
  assign w_match    = (TDEST == MY_DEST);
  assign w_store    = w_accept && (((r_state == IDLE) && w_match) || (r_state == RECV)) &&
                      (w_keep_any || TLAST);
  assign w_cnt_next = (w_keep_any && (r_cnt != 16'hFFFF)) ? r_cnt + 16'd1 : r_cnt;
  assign w_pop      = out_valid && out_ready;

  assign w_in_beat = '{data: TDATA, keep: TKEEP, user: TUSER, id: TID, last: TLAST};

  axis_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BW)
  ) u_fifo (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .i_push  (w_store),
    .i_din   (w_in_beat),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Head fields read as zero while empty so stale storage never leaks out.
  assign w_head    = w_empty ? '0 : beat_t'(w_fifo_dout);
  assign out_valid = !w_empty;
  assign out_data  = w_head.data;
  assign out_keep  = w_head.keep;
  assign out_user  = w_head.user;
  assign out_id    = w_head.id;
  assign out_last  = w_head.last;
  assign pkt_len   = r_pkt_len;
  assign pkt_done  = r_pkt_done;
  assign drop_err  = r_drop_err;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= IDLE;
      r_rdy_en   <= 1'b0;
      r_cnt      <= '0;
      r_pkt_len  <= '0;
      r_pkt_done <= 1'b0;
      r_drop_err <= 1'b0;
    end else begin
      r_rdy_en   <= 1'b1;
      r_pkt_done <= 1'b0;
      r_drop_err <= 1'b0;
      if (w_store) begin
        if (TLAST) begin
          r_pkt_len  <= w_cnt_next;
          r_pkt_done <= 1'b1;
          r_cnt      <= '0;
        end else begin
          r_cnt <= w_cnt_next;
        end
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_match) begin
              r_state <= TLAST ? IDLE : RECV;
            end else begin
              r_drop_err <= 1'b1;
              r_state    <= TLAST ? IDLE : DROP;
            end
          end
        end
        RECV: if (w_accept && TLAST) r_state <= IDLE;
        DROP: if (w_accept && TLAST) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_receiver.sv
// Directed bench for axi_stream_receiver: per-cycle vector table plus multi-cycle sequences.
module tb_axi_stream_receiver;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        TVALID;
  logic        TREADY;
  logic [15:0] TDATA;
  logic [1:0]  TKEEP;
  logic [1:0]  TSTRB;
  logic        TLAST;
  logic [1:0]  TUSER;
  logic        TID;
  logic [7:0]  TDEST;
  logic [15:0] out_data;
  logic [1:0]  out_keep;
  logic [1:0]  out_user;
  logic        out_id;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] pkt_len;
  logic        pkt_done;
  logic        drop_err;

  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  axi_stream_receiver #(
    .DATA_WIDTH (16),
    .FIFO_DEPTH (4),
    .MY_DEST    (8'h00)
  ) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .TVALID    (TVALID),
    .TREADY    (TREADY),
    .TDATA     (TDATA),
    .TKEEP     (TKEEP),
    .TSTRB     (TSTRB),
    .TLAST     (TLAST),
    .TUSER     (TUSER),
    .TID       (TID),
    .TDEST     (TDEST),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_user  (out_user),
    .out_id    (out_id),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pkt_len   (pkt_len),
    .pkt_done  (pkt_done),
    .drop_err  (drop_err)
  );

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic [1:0]  k;
    logic        l;
    logic [7:0]  dest;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [15:0] e_d;
    logic [1:0]  e_k;
    logic        e_l;
    logic        e_done;
    logic        e_drop;
    logic [15:0] e_len;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] k,
                       input logic l, input logic [7:0] dest);
    TVALID = v;
    TDATA  = d;
    TKEEP  = k;
    TSTRB  = k;
    TLAST  = l;
    TDEST  = dest;
  endtask

  task automatic next_cycle();
    @(posedge ACLK);
    #1;
  endtask

  // Holds a beat until accepted, bounded by a cycle budget.
  task automatic send_beat(input logic [15:0] d, input logic l);
    logic acc;
    acc = 1'b0;
    drive(1'b1, d, 2'b11, l, 8'h00);
    for (int c = 0; c < 20 && !acc; c++) begin
      @(negedge ACLK);
      acc = TREADY;
      next_cycle();
    end
    chk("send_accept", int'(acc), 1);
    drive(1'b0, 16'h0, 2'b00, 1'b0, 8'h00);
  endtask

  initial begin
    logic [15:0] rx_d [$];
    logic        rx_l [$];
    int          acc;
    int          done_cnt;
    logic        w;
    logic        seen;

    tbl[0]  = '{1'b1,16'h0001,2'b11,1'b0,8'h00,1'b1, 1'b1,1'b0,16'h0000,2'b00,1'b0,1'b0,1'b0,16'd0};
    tbl[1]  = '{1'b1,16'h0002,2'b11,1'b0,8'h00,1'b1, 1'b1,1'b1,16'h0001,2'b11,1'b0,1'b0,1'b0,16'd0};
    tbl[2]  = '{1'b1,16'h0003,2'b11,1'b1,8'h00,1'b1, 1'b1,1'b1,16'h0002,2'b11,1'b0,1'b0,1'b0,16'd0};
    tbl[3]  = '{1'b0,16'h0000,2'b00,1'b0,8'h00,1'b1, 1'b1,1'b1,16'h0003,2'b11,1'b1,1'b1,1'b0,16'd3};
    tbl[4]  = '{1'b1,16'h00AA,2'b11,1'b0,8'h05,1'b1, 1'b1,1'b0,16'h0000,2'b00,1'b0,1'b0,1'b0,16'd3};
    tbl[5]  = '{1'b1,16'h00BB,2'b11,1'b1,8'h05,1'b1, 1'b1,1'b0,16'h0000,2'b00,1'b0,1'b0,1'b1,16'd3};
    tbl[6]  = '{1'b1,16'h0011,2'b11,1'b1,8'h00,1'b1, 1'b1,1'b0,16'h0000,2'b00,1'b0,1'b0,1'b0,16'd3};
    tbl[7]  = '{1'b0,16'h0000,2'b00,1'b0,8'h00,1'b1, 1'b1,1'b1,16'h0011,2'b11,1'b1,1'b1,1'b0,16'd1};
    tbl[8]  = '{1'b0,16'h0000,2'b00,1'b0,8'h00,1'b1, 1'b1,1'b0,16'h0000,2'b00,1'b0,1'b0,1'b0,16'd1};
    tbl[9]  = '{1'b1,16'h0021,2'b11,1'b0,8'h00,1'b1, 1'b1,1'b0,16'h0000,2'b00,1'b0,1'b0,1'b0,16'd1};
    tbl[10] = '{1'b1,16'h0022,2'b00,1'b0,8'h00,1'b1, 1'b1,1'b1,16'h0021,2'b11,1'b0,1'b0,1'b0,16'd1};
    tbl[11] = '{1'b1,16'h0023,2'b01,1'b0,8'h00,1'b1, 1'b1,1'b0,16'h0000,2'b00,1'b0,1'b0,1'b0,16'd1};
    tbl[12] = '{1'b1,16'h0024,2'b00,1'b1,8'h00,1'b1, 1'b1,1'b1,16'h0023,2'b01,1'b0,1'b0,1'b0,16'd1};
    tbl[13] = '{1'b0,16'h0000,2'b00,1'b0,8'h00,1'b1, 1'b1,1'b1,16'h0024,2'b00,1'b1,1'b1,1'b0,16'd2};
    tbl[14] = '{1'b0,16'h0000,2'b00,1'b0,8'h00,1'b1, 1'b1,1'b0,16'h0000,2'b00,1'b0,1'b0,1'b0,16'd2};

    ARESETn   = 1'b0;
    out_ready = 1'b0;
    TUSER     = 2'b00;
    TID       = 1'b0;
    drive(1'b0, 16'h0, 2'b00, 1'b0, 8'h00);

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_tready", int'(TREADY), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_pkt_len", int'(pkt_len), 0);
    chk("rst_pkt_done", int'(pkt_done), 0);
    chk("rst_drop_err", int'(drop_err), 0);

    next_cycle();
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("tready_before_en", int'(TREADY), 0);
    next_cycle();

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].k, tbl[i].l, tbl[i].dest);
      out_ready = tbl[i].ordy;
      @(negedge ACLK);
      chk($sformatf("v%0d_tready", i),    int'(TREADY),    int'(tbl[i].e_rdy));
      chk($sformatf("v%0d_out_valid", i), int'(out_valid), int'(tbl[i].e_ov));
      chk($sformatf("v%0d_out_data", i),  int'(out_data),  int'(tbl[i].e_d));
      chk($sformatf("v%0d_out_keep", i),  int'(out_keep),  int'(tbl[i].e_k));
      chk($sformatf("v%0d_out_last", i),  int'(out_last),  int'(tbl[i].e_l));
      chk($sformatf("v%0d_pkt_done", i),  int'(pkt_done),  int'(tbl[i].e_done));
      chk($sformatf("v%0d_drop_err", i),  int'(drop_err),  int'(tbl[i].e_drop));
      chk($sformatf("v%0d_pkt_len", i),   int'(pkt_len),   int'(tbl[i].e_len));
      next_cycle();
    end

    // Backpressure: six beats with the consumer stalled, then drained.
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      drive(acc < 6, 16'h0031 + 16'(acc), 2'b11, acc == 5, 8'h00);
      @(negedge ACLK);
      w = TVALID && TREADY;
      next_cycle();
      if (w) acc++;
    end
    drive(acc < 6, 16'h0031 + 16'(acc), 2'b11, acc == 5, 8'h00);
    @(negedge ACLK);
    chk("bp_accepted", acc, 4);
    chk("bp_tready_full", int'(TREADY), 0);
    next_cycle();
    out_ready = 1'b1;
    done_cnt  = 0;
    for (int c = 0; c < 30 && rx_d.size() < 6; c++) begin
      drive(acc < 6, 16'h0031 + 16'(acc), 2'b11, acc == 5, 8'h00);
      @(negedge ACLK);
      w = TVALID && TREADY;
      if (out_valid) begin
        rx_d.push_back(out_data);
        rx_l.push_back(out_last);
      end
      if (pkt_done) done_cnt++;
      next_cycle();
      if (w) acc++;
    end
    drive(1'b0, 16'h0, 2'b00, 1'b0, 8'h00);
    chk("bp_rx_count", rx_d.size(), 6);
    for (int i = 0; i < rx_d.size(); i++) begin
      chk($sformatf("bp_data%0d", i), int'(rx_d[i]), 'h31 + i);
      chk($sformatf("bp_last%0d", i), int'(rx_l[i]), (i == 5) ? 1 : 0);
    end
    repeat (2) begin
      @(negedge ACLK);
      if (pkt_done) done_cnt++;
      next_cycle();
    end
    chk("bp_done_pulses", done_cnt, 1);
    chk("bp_pkt_len", int'(pkt_len), 6);

    // Push and pop in the same cycle at occupancy 3.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h0041 + 16'(i), 2'b11, 1'b0, 8'h00);
      TUSER = (i == 0) ? 2'b01 : 2'b00;
      TID   = (i == 0);
      @(negedge ACLK);
      chk($sformatf("pp_fill%0d_tready", i), int'(TREADY), 1);
      next_cycle();
    end
    TUSER = 2'b00;
    TID   = 1'b0;
    drive(1'b1, 16'h0044, 2'b11, 1'b0, 8'h00);
    out_ready = 1'b1;
    @(negedge ACLK);
    chk("pp_tready_occ3", int'(TREADY), 1);
    chk("pp_head41", int'(out_data), 'h41);
    chk("pp_head_user", int'(out_user), 1);
    chk("pp_head_id", int'(out_id), 1);
    next_cycle();
    drive(1'b1, 16'h0045, 2'b11, 1'b1, 8'h00);
    out_ready = 1'b0;
    @(negedge ACLK);
    chk("pp_tready_still_occ3", int'(TREADY), 1);
    chk("pp_head42", int'(out_data), 'h42);
    chk("pp_head_user0", int'(out_user), 0);
    next_cycle();
    drive(1'b0, 16'h0, 2'b00, 1'b0, 8'h00);
    @(negedge ACLK);
    chk("pp_tready_occ4", int'(TREADY), 0);
    chk("pp_pkt_done", int'(pkt_done), 1);
    chk("pp_pkt_len", int'(pkt_len), 5);
    next_cycle();
    out_ready = 1'b1;
    rx_d.delete();
    for (int c = 0; c < 10 && rx_d.size() < 4; c++) begin
      @(negedge ACLK);
      if (out_valid) rx_d.push_back(out_data);
      next_cycle();
    end
    chk("pp_rx_count", rx_d.size(), 4);
    for (int i = 0; i < rx_d.size(); i++)
      chk($sformatf("pp_data%0d", i), int'(rx_d[i]), 'h42 + i);

    // Reset asserted in the middle of a four-beat packet.
    out_ready = 1'b0;
    send_beat(16'h0051, 1'b0);
    send_beat(16'h0052, 1'b0);
    chk("mr_pre_valid", int'(out_valid), 1);
    #2;
    ARESETn = 1'b0;
    #1;
    chk("mr_tready", int'(TREADY), 0);
    chk("mr_out_valid", int'(out_valid), 0);
    chk("mr_out_data", int'(out_data), 0);
    chk("mr_out_last", int'(out_last), 0);
    chk("mr_pkt_len", int'(pkt_len), 0);
    chk("mr_pkt_done", int'(pkt_done), 0);
    seen = 1'b0;
    repeat (2) begin
      @(negedge ACLK);
      if (pkt_done) seen = 1'b1;
    end
    chk("mr_no_done", int'(seen), 0);
    next_cycle();
    ARESETn = 1'b1;
    next_cycle();
    out_ready = 1'b1;
    send_beat(16'h0061, 1'b0);
    send_beat(16'h0062, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge ACLK);
      if (pkt_done) seen = 1'b1;
      if (!seen) next_cycle();
    end
    chk("mr_new_done", int'(seen), 1);
    chk("mr_new_len", int'(pkt_len), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_stream_receiver.md
# axi_stream_receiver

AXI-Stream slave that terminates the stream driven by the SHA3 AXIS transmitter and hands beats to the hash core's absorb logic. It filters packets by TDEST, buffers accepted beats in a small show-ahead FIFO, and reports per-packet beat counts. It discards keep-less null beats and drops whole packets addressed elsewhere.

## Interface
- DATA_WIDTH, 16: TDATA width in bits, a multiple of 8; KW = DATA_WIDTH/8.
- FIFO_DEPTH, 4: buffer entries, a power of 2 and at least 2.
- MY_DEST, 8'h00: TDEST value this receiver accepts.
- ACLK in 1: single clock, rising edge.
- ARESETn in 1: asynchronous, active-low reset.
- TVALID in 1: beat valid.
- TREADY out 1: beat accept.
- TDATA in DATA_WIDTH: payload.
- TKEEP in KW: byte-keep.
- TSTRB in KW: byte-strobe; must equal TKEEP and is otherwise ignored.
- TLAST in 1: last beat of the packet.
- TUSER in 2: sideband, passed through.
- TID in 1: stream id, passed through.
- TDEST in 8: destination.
- out_data out DATA_WIDTH, out_keep out KW, out_user out 2, out_id out 1, out_last out 1: FIFO head fields.
- out_valid out 1: FIFO not empty.
- out_ready in 1: consumer pops the head when out_valid && out_ready.
- pkt_len out 16: beat count of the last completed accepted packet.
- pkt_done out 1: one-cycle pulse when pkt_len updates.
- drop_err out 1: one-cycle pulse on the first beat of a dropped packet.

## Operation
- A beat is accepted when TVALID && TREADY on a rising edge of ACLK.
- FSM states, held in a 2-bit register:
  - IDLE: between packets.
  - RECV: inside an accepted packet.
  - DROP: inside a rejected packet.
- IDLE, accepted beat:
  - If TDEST == MY_DEST, the beat is stored. Go to RECV, or stay in IDLE if TLAST.
  - If TDEST != MY_DEST, pulse drop_err and discard the beat. Go to DROP, or stay in IDLE if TLAST.
- RECV: TDEST is not rechecked mid-packet. An accepted beat with TLAST returns to IDLE.
- DROP: TREADY = 1 regardless of FIFO level. Accepted beats are discarded; TLAST returns to IDLE.
- Store rules in IDLE/RECV:
  - A beat is written to the FIFO unless TKEEP == 0 && !TLAST. Such a null beat is accepted and dropped silently.
  - A TKEEP == 0 beat with TLAST is written, so the last marker reaches the consumer.
- Beat counter (16 bits):
  - Increments on each stored beat with TKEEP != 0 and saturates at 16'hFFFF.
  - On a stored TLAST beat, pkt_len <= final count, including that beat if its TKEEP != 0. pkt_done pulses and the counter clears.
- TREADY in IDLE/RECV = rdy_en && !full. rdy_en is a flop that goes to 1 on the first ACLK edge after ARESETn deasserts.
- Simultaneous push and pop: allowed whenever not full. Occupancy stays unchanged.

## Timing
- Reset values:
  - TREADY = 0, out_valid = 0.
  - out_data, out_keep, out_user, out_id, out_last = 0.
  - pkt_len = 0, pkt_done = 0, drop_err = 0.
  - FSM = IDLE, FIFO empty, counter = 0.
- First TREADY = 1: one cycle after ARESETn rises.
- Latency: a beat accepted at edge N has out_valid = 1 after edge N (show-ahead FIFO, 1 cycle). pkt_done and drop_err are registered and assert after the accepting edge.
- TREADY responds combinationally to FIFO state. It drops in the cycle the FIFO becomes full and returns in the cycle after a pop.
- Full FIFO with out_ready = 1: the pop frees a slot, and TREADY rises the following cycle.
- Reset asserted mid-packet: all state clears immediately and asynchronously. The partial packet is lost, and pkt_done does not pulse.

## Structure
- Package axis_pkg:
  - rx_state_t enum: IDLE, RECV, DROP.
  - AXIS_USER_W = 2 and AXIS_DEST_W = 8.
  - A beat struct {data, keep, user, id, last} parameterised via DATA_WIDTH.
- Sub-module axis_sync_fifo (DEPTH, WIDTH): show-ahead FIFO with wrap-around pointers plus an extra bit for full/empty. This module is reused by later blocks.

## Test plan
- After reset, send a 3-beat packet with TDEST = 0, TKEEP = 2'b11, data 1/2/3 and out_ready = 1 -> out_data 1, 2, 3 in order, out_last on beat 3, pkt_len = 3, one pkt_done pulse.
- Send a 2-beat packet with TDEST = 8'h05 -> TREADY stays 1, one drop_err pulse, nothing on out_valid. A following TDEST = 0 packet is received normally.
- Hold out_ready = 0 and stream 6 beats -> TREADY = 0 after 4 accepts. Release out_ready -> all 6 beats come out in order with no loss or duplication.
- Send the middle beat with TKEEP = 0 and no TLAST, then a last beat with TKEEP = 0 and TLAST -> only the valid beats plus the last marker appear on the output; pkt_len counts only TKEEP != 0 beats.
- Assert ARESETn = 0 after beat 2 of 4 -> all outputs return to reset values immediately, and no pkt_done pulse. A new packet after reset gives the correct pkt_len.
- Push and pop in the same cycle at occupancy 3 -> occupancy stays 3 and TREADY stays 1.
